// File: rtl/vscpu_param_hs.sv
// rtl/vscpu_param_hs.sv - parametrised multi-cycle VerySimpleCPU core with a req/ack memory port
// One access in flight at a time; every memory-facing output is a register.
module vscpu_param_hs #(
    parameter int DW = 32,
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          rst,
    output logic          mem_req,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          retired,
    output logic          halted
);

    if (DW < 4 + 2 * AW) begin : g_width_check
        $error("vscpu_param_hs: DW must be at least 4+2*AW");
    end

    localparam logic [3:0] OP_CP    = 4'h8;
    localparam logic [3:0] OP_CPIMM = 4'h9;
    localparam logic [3:0] OP_CPI   = 4'hA;
    localparam logic [3:0] OP_CPII  = 4'hB;
    localparam logic [3:0] OP_BZJ   = 4'hC;
    localparam logic [3:0] OP_BZJI  = 4'hD;
    localparam logic [DW-1:0] DW_V  = DW'(DW);

    typedef enum logic [2:0] {
        S_RST,
        S_FETCH,
        S_RDA,
        S_RDB,
        S_RDI,
        S_WR,
        S_HALT
    } state_t;

    state_t        state_q;
    logic [AW-1:0] pc_q;
    logic [3:0]    op_q;
    logic [AW-1:0] a_q;
    logic [AW-1:0] b_q;
    logic [DW-1:0] va_q;
    logic          mem_req_q;
    logic          mem_wr_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          halted_q;

    logic [3:0]    f_op;
    logic [AW-1:0] f_a;
    logic [AW-1:0] f_b;
    logic [DW-1:0] imm_ext;
    logic [DW-1:0] bzji_sum;
    logic [AW-1:0] br_pc_d;
    logic          branch_op;

    assign f_op     = mem_rdata[DW-1 -: 4];
    assign f_a      = mem_rdata[2*AW-1 -: AW];
    assign f_b      = mem_rdata[AW-1:0];
    assign imm_ext  = {{(DW-AW){1'b0}}, b_q};
    assign bzji_sum = mem_rdata + imm_ext;
    assign branch_op = (op_q == OP_BZJ) || (op_q == OP_BZJI);

    function automatic logic reads_a(input logic [3:0] op);
        return !(op == OP_CP || op == OP_CPIMM || op == OP_CPI);
    endfunction

    function automatic logic reads_b(input logic [3:0] op);
        return !op[0] || (op == OP_CPII);
    endfunction

    // Copy-type ops (CP, CPi, CPI, CPIi) fall through to passing y unchanged.
    function automatic logic [DW-1:0] alu(input logic [3:0] op, input logic [DW-1:0] x,
                                          input logic [DW-1:0] y);
        logic [DW-1:0] r;
        case (op[3:1])
            3'd0:    r = x + y;
            3'd1:    r = ~(x & y);
            3'd2:    r = (y < DW_V) ? (x >> y) : (x << (y - DW_V));
            3'd3:    r = {{(DW-1){1'b0}}, (x < y)};
            3'd7:    r = x * y;
            default: r = y;
        endcase
        return r;
    endfunction

    // Branch target: RDA resolves a taken BZJ or a BZJi, RDB resolves an untaken BZJ.
    always_comb begin
        br_pc_d = pc_q + 1'b1;
        if (state_q == S_RDA) begin
            br_pc_d = (op_q == OP_BZJ) ? mem_rdata[AW-1:0] : bzji_sum[AW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RST;
            pc_q        <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            va_q        <= '0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            case (state_q)
                S_RST: begin
                    state_q    <= S_FETCH;
                    mem_req_q  <= 1'b1;
                    mem_wr_q   <= 1'b0;
                    mem_addr_q <= pc_q;
                end
                S_FETCH: if (mem_ack) begin
                    op_q     <= f_op;
                    a_q      <= f_a;
                    b_q      <= f_b;
                    mem_wr_q <= 1'b0;
                    if (reads_a(f_op) && f_op != OP_BZJ) begin
                        state_q    <= S_RDA;
                        mem_addr_q <= f_a;
                    end else if (reads_b(f_op)) begin
                        state_q    <= S_RDB;
                        mem_addr_q <= f_b;
                    end else begin
                        state_q     <= S_WR;
                        mem_wr_q    <= 1'b1;
                        mem_addr_q  <= f_a;
                        mem_wdata_q <= {{(DW-AW){1'b0}}, f_b};
                    end
                end
                S_RDA: if (mem_ack) begin
                    va_q <= mem_rdata;
                    if (branch_op) begin
                        if (br_pc_d == pc_q) begin
                            state_q   <= S_HALT;
                            mem_req_q <= 1'b0;
                            halted_q  <= 1'b1;
                        end else begin
                            state_q    <= S_FETCH;
                            pc_q       <= br_pc_d;
                            mem_addr_q <= br_pc_d;
                        end
                    end else if (reads_b(op_q)) begin
                        state_q    <= S_RDB;
                        mem_addr_q <= b_q;
                    end else begin
                        state_q     <= S_WR;
                        mem_wr_q    <= 1'b1;
                        mem_addr_q  <= a_q;
                        mem_wdata_q <= alu(op_q, mem_rdata, imm_ext);
                    end
                end
                S_RDB: if (mem_ack) begin
                    if (op_q == OP_BZJ) begin
                        if (mem_rdata == '0) begin
                            state_q    <= S_RDA;
                            mem_addr_q <= a_q;
                        end else if (br_pc_d == pc_q) begin
                            state_q   <= S_HALT;
                            mem_req_q <= 1'b0;
                            halted_q  <= 1'b1;
                        end else begin
                            state_q    <= S_FETCH;
                            pc_q       <= br_pc_d;
                            mem_addr_q <= br_pc_d;
                        end
                    end else if (op_q == OP_CPI) begin
                        state_q    <= S_RDI;
                        mem_addr_q <= mem_rdata[AW-1:0];
                    end else begin
                        state_q     <= S_WR;
                        mem_wr_q    <= 1'b1;
                        mem_addr_q  <= (op_q == OP_CPII) ? va_q[AW-1:0] : a_q;
                        mem_wdata_q <= alu(op_q, va_q, mem_rdata);
                    end
                end
                S_RDI: if (mem_ack) begin
                    state_q     <= S_WR;
                    mem_wr_q    <= 1'b1;
                    mem_addr_q  <= a_q;
                    mem_wdata_q <= mem_rdata;
                end
                S_WR: if (mem_ack) begin
                    state_q    <= S_FETCH;
                    pc_q       <= pc_q + 1'b1;
                    mem_wr_q   <= 1'b0;
                    mem_addr_q <= pc_q + 1'b1;
                end
                S_HALT: begin
                    mem_req_q <= 1'b0;
                end
                default: begin
                    state_q   <= S_RST;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign halted    = halted_q;
    // Retire on the ack that ends the instruction: its write, or the read that resolves a branch.
    assign retired   = !rst && mem_ack &&
                       ((state_q == S_WR) ||
                        (state_q == S_RDA && branch_op) ||
                        (state_q == S_RDB && op_q == OP_BZJ && mem_rdata != '0));

endmodule

// File: tb/tb_vscpu_param_hs.sv
// tb/tb_vscpu_param_hs.sv - bench for vscpu_param_hs: directed programs plus random programs vs an ISS
module tb_vscpu_param_hs;
    localparam int MW = 16384;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_wr, mem_ack, retired, halted;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic        s_rst = 1'b1;
    logic        s_req, s_wr, s_ack, s_retired, s_halted;
    logic [3:0]  s_addr;
    logic [15:0] s_wdata, s_rdata;

    int total = 0;
    int bad = 0;

    logic [31:0] img [0:MW-1];
    logic [31:0] mem [0:MW-1];
    logic [31:0] rm  [0:MW-1];
    int          wait_fixed = 0;
    bit          wait_rand = 1'b0;
    int          wait_cur, cnt;
    int          stab_err = 0;
    int          wr_log[$];
    logic        p_pend, p_wr;
    logic [13:0] p_addr;
    logic [31:0] p_wdata;

    logic [15:0] s_img [0:15];
    logic [15:0] s_mem [0:15];
    logic [4:0]  s_log[$];

    always #5 clk = ~clk;

    vscpu_param_hs #(.DW(32), .AW(14)) u_dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .retired(retired), .halted(halted)
    );

    vscpu_param_hs #(.DW(16), .AW(4)) u_small (
        .clk(clk), .rst(s_rst), .mem_req(s_req), .mem_wr(s_wr), .mem_addr(s_addr),
        .mem_wdata(s_wdata), .mem_ack(s_ack), .mem_rdata(s_rdata),
        .retired(s_retired), .halted(s_halted)
    );

    // RAM with programmable wait states; it also flags any request that changes while stalled.
    assign mem_ack   = mem_req && (cnt >= wait_cur);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MW; i++) mem[i] <= img[i];
            cnt      <= 0;
            wait_cur <= wait_fixed;
            p_pend   <= 1'b0;
        end else begin
            if (p_pend && (!mem_req || mem_addr != p_addr || mem_wr != p_wr || mem_wdata != p_wdata))
                stab_err <= stab_err + 1;
            p_pend  <= mem_req && !mem_ack;
            p_addr  <= mem_addr;
            p_wr    <= mem_wr;
            p_wdata <= mem_wdata;
            if (mem_req && mem_ack) begin
                if (mem_wr) begin
                    mem[mem_addr] <= mem_wdata;
                    wr_log.push_back(int'(mem_addr));
                end
                cnt      <= 0;
                wait_cur <= wait_rand ? int'($urandom_range(0, 3)) : wait_fixed;
            end else if (mem_req) begin
                cnt <= cnt + 1;
            end else begin
                cnt <= 0;
            end
        end
    end

    assign s_ack   = s_req;
    assign s_rdata = s_mem[s_addr];

    always @(posedge clk) begin
        if (s_rst) begin
            for (int i = 0; i < 16; i++) s_mem[i] <= s_img[i];
        end else if (s_req && s_ack) begin
            if (s_wr) s_mem[s_addr] <= s_wdata;
            s_log.push_back({s_wr, s_addr});
        end
    end

    function automatic logic [31:0] enc(input logic [3:0] op, input int a, input int b);
        logic [13:0] fa, fb;
        fa = a[13:0];
        fb = b[13:0];
        return {op, fa, fb};
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x,
                                            input logic [31:0] y);
        logic [63:0] p;
        case (op)
            4'd0, 4'd1: return x + y;
            4'd2, 4'd3: return ~(x & y);
            4'd4, 4'd5: begin
                if (y < 32) return x >> y;
                if (y - 32 < 32) return x << (y - 32);
                return 32'd0;
            end
            4'd6, 4'd7: return (x < y) ? 32'd1 : 32'd0;
            4'd14, 4'd15: begin
                p = {32'd0, x} * {32'd0, y};
                return p[31:0];
            end
            default: return y;
        endcase
    endfunction

    // Instruction-set model over rm[]; counts retired instructions and memory accesses.
    task automatic ref_run(input int max_steps, output int n_ret, output int n_acc, output bit hlt);
        logic [13:0] pc, npc, a, b, ptr;
        logic [31:0] iw, imm, t;
        logic [3:0]  op;
        pc = 0; n_ret = 0; n_acc = 0; hlt = 0;
        for (int s = 0; s < max_steps; s++) begin
            iw = rm[pc]; op = iw[31:28]; a = iw[27:14]; b = iw[13:0];
            imm = {18'd0, b};
            n_acc++;
            npc = pc + 14'd1;
            case (op)
                4'd8:  begin rm[a] = rm[b]; n_acc += 2; end
                4'd9:  begin rm[a] = imm; n_acc += 1; end
                4'd10: begin ptr = rm[b][13:0]; rm[a] = rm[ptr]; n_acc += 3; end
                4'd11: begin ptr = rm[a][13:0]; rm[ptr] = rm[b]; n_acc += 3; end
                4'd12: begin
                    n_acc++;
                    if (rm[b] == 0) begin n_acc++; npc = rm[a][13:0]; end
                end
                4'd13: begin n_acc++; t = rm[a] + imm; npc = t[13:0]; end
                default: begin
                    if (op[0]) begin rm[a] = ref_alu(op, rm[a], imm); n_acc += 2; end
                    else begin rm[a] = ref_alu(op, rm[a], rm[b]); n_acc += 3; end
                end
            endcase
            n_ret++;
            if ((op == 4'd12 || op == 4'd13) && npc == pc) begin hlt = 1; break; end
            pc = npc;
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < MW; i++) img[i] = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_big(input int budget, output int cycles, output int rets, output int first_ret);
        cycles = 0; rets = 0; first_ret = 0;
        while (cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (halted) break;
            if (retired) begin
                rets++;
                if (first_ret == 0) first_ret = cycles;
            end
        end
    endtask

    task automatic load_add();
        clear_img();
        img[0] = enc(4'h0, 20, 21);
        img[1] = enc(4'hD, 22, 1);
        img[20] = 32'd5; img[21] = 32'd7;
    endtask

    task automatic test_reset();
        load_add();
        wait_fixed = 3;
        do_reset();
        repeat (6) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({mem_req, mem_wr, retired, halted} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got req/wr/ret/halt=%b want 0000", {mem_req, mem_wr, retired, halted});
        end
        total++;
        if (mem_addr !== 14'd0 || mem_wdata !== 32'd0) begin
            bad++; $display("FAIL reset_bus got addr=%0d wdata=%h want 0/0", mem_addr, mem_wdata);
        end
        rst = 1'b0;
        total++;
        if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_state got req=%b want 0", mem_req); end
        @(negedge clk);
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 14'd0 || mem_wr !== 1'b0) begin
            bad++; $display("FAIL first_fetch got req=%b addr=%0d wr=%b want 1/0/0", mem_req, mem_addr, mem_wr);
        end
    endtask

    task automatic test_add();
        int cyc, rets, fr;
        load_add();
        wait_fixed = 0;
        do_reset();
        run_big(200, cyc, rets, fr);
        total++;
        if (!halted) begin bad++; $display("FAIL add_halt got halted=0 after %0d cycles want 1", cyc); end
        total++;
        if (fr != 4) begin bad++; $display("FAIL add_latency got %0d want 4", fr); end
        total++;
        if (mem[20] !== 32'd12) begin bad++; $display("FAIL add_result got %0d want 12", mem[20]); end
        total++;
        if (cyc != 7 || rets != 2) begin bad++; $display("FAIL add_cycles got cyc=%0d ret=%0d want 7/2", cyc, rets); end
    endtask

    task automatic test_wait_states();
        int cyc, rets, fr, log0, st0, n20;
        load_add();
        wait_fixed = 3;
        log0 = wr_log.size(); st0 = stab_err;
        do_reset();
        run_big(400, cyc, rets, fr);
        n20 = 0;
        for (int i = log0; i < wr_log.size(); i++) if (wr_log[i] == 20) n20++;
        total++;
        if (fr != 16) begin bad++; $display("FAIL wait_latency got %0d want 16", fr); end
        total++;
        if (mem[20] !== 32'd12 || n20 != 1) begin
            bad++; $display("FAIL wait_result got %0d writes=%0d want 12/1", mem[20], n20);
        end
        total++;
        if (stab_err != st0) begin bad++; $display("FAIL wait_stable got %0d changes want 0", stab_err - st0); end
        total++;
        if (cyc != 25 || !halted) begin bad++; $display("FAIL wait_cycles got %0d halt=%b want 25/1", cyc, halted); end
    endtask

    task automatic test_srl_lt();
        int cyc, rets, fr;
        clear_img();
        img[0] = enc(4'h5, 100, 31);
        img[1] = enc(4'h5, 101, 32);
        img[2] = enc(4'h4, 102, 110);
        img[3] = enc(4'h7, 103, 5);
        img[4] = enc(4'h6, 104, 111);
        img[5] = enc(4'hD, 120, 5);
        img[100] = 32'h80000000; img[101] = 32'h80000000; img[102] = 32'h80000000;
        img[103] = 32'hFFFFFFFF; img[104] = 32'd3;
        img[110] = 32'd33; img[111] = 32'hFFFFFFFF;
        wait_fixed = 1;
        do_reset();
        run_big(400, cyc, rets, fr);
        total++;
        if (mem[100] !== 32'd1 || mem[101] !== 32'h80000000) begin
            bad++; $display("FAIL srl_31_32 got %h %h want 00000001 80000000", mem[100], mem[101]);
        end
        total++;
        if (mem[102] !== 32'd0) begin bad++; $display("FAIL srl_33 got %h want 0", mem[102]); end
        total++;
        if (mem[103] !== 32'd0 || mem[104] !== 32'd1) begin
            bad++; $display("FAIL lt_unsigned got %h %h want 0 1", mem[103], mem[104]);
        end
    endtask

    task automatic test_indirect();
        int cyc, rets, fr, log0;
        clear_img();
        img[0] = enc(4'hA, 70, 71);
        img[1] = enc(4'hB, 72, 73);
        img[2] = enc(4'hD, 74, 2);
        img[71] = 32'd30; img[30] = 32'hABCD; img[72] = 32'd40; img[73] = 32'd9;
        wait_fixed = 0;
        log0 = wr_log.size();
        do_reset();
        run_big(200, cyc, rets, fr);
        total++;
        if (mem[70] !== 32'hABCD) begin bad++; $display("FAIL cpi got %h want abcd", mem[70]); end
        total++;
        if (mem[40] !== 32'd9 || mem[72] !== 32'd40) begin
            bad++; $display("FAIL cpii got M40=%0d M72=%0d want 9/40", mem[40], mem[72]);
        end
        total++;
        if (wr_log.size() != log0 + 2 || wr_log[log0] != 70 || wr_log[log0+1] != 40) begin
            bad++; $display("FAIL ind_wr_addrs got n=%0d want writes to 70 then 40", wr_log.size() - log0);
        end
        total++;
        if (cyc != 11) begin bad++; $display("FAIL ind_cycles got %0d want 11", cyc); end
    endtask

    task automatic test_branch_halt();
        int cyc, rets, fr, viol;
        clear_img();
        img[0] = enc(4'hC, 50, 51);
        for (int i = 1; i < 6; i++) img[i] = enc(4'h9, 61, 1);
        img[6] = enc(4'hC, 50, 52);
        img[7] = enc(4'h9, 60, 32'h55);
        img[8] = enc(4'hD, 53, 0);
        img[50] = 32'd6; img[52] = 32'd3; img[53] = 32'd8;
        wait_fixed = 0;
        do_reset();
        run_big(200, cyc, rets, fr);
        total++;
        if (mem[61] !== 32'd0 || mem[60] !== 32'h55) begin
            bad++; $display("FAIL bzj_path got M61=%0d M60=%h want 0/55", mem[61], mem[60]);
        end
        total++;
        if (cyc != 10 || rets != 4 || !halted) begin
            bad++; $display("FAIL bzj_timing got cyc=%0d ret=%0d halt=%b want 10/4/1", cyc, rets, halted);
        end
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_req !== 1'b0 || halted !== 1'b1 || retired !== 1'b0) viol++;
        end
        total++;
        if (viol != 0) begin bad++; $display("FAIL halt_hold got %0d bad cycles want 0", viol); end
    endtask

    task automatic test_reset_mid();
        bit found;
        load_add();
        wait_fixed = 3;
        do_reset();
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_req && !mem_wr && mem_addr == 14'd21 && !mem_ack) begin found = 1; break; end
        end
        total++;
        if (!found) begin bad++; $display("FAIL mid_rdb got no pending read of 21 want one"); end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (mem_req !== 1'b0) begin bad++; $display("FAIL mid_drop got req=%b want 0", mem_req); end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 14'd0 || mem_wr !== 1'b0) begin
            bad++; $display("FAIL mid_refetch got req=%b addr=%0d want 1/0", mem_req, mem_addr);
        end
    endtask

    task automatic test_random();
        int n, cyc, rets, fr, r_ret, r_acc, diffs, w;
        bit r_hlt;
        logic [3:0] op;
        logic [3:0] ops [13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd14, 4'd15};
        for (int it = 0; it < 6; it++) begin
            clear_img();
            n = 8 + int'($urandom_range(0, 16));
            for (int i = 0; i < n; i++) begin
                op = ops[$urandom_range(0, 12)];
                if (op[0])
                    img[i] = enc(op, 100 + int'($urandom_range(0, 7)),
                                 ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 16383)));
                else
                    img[i] = enc(op, 100 + int'($urandom_range(0, 7)), 100 + int'($urandom_range(0, 15)));
            end
            img[n] = enc(4'hD, 200, n);
            for (int j = 0; j < 16; j++) img[100+j] = (j < 4) ? $urandom_range(0, 40) : $urandom;
            for (int i = 0; i < MW; i++) rm[i] = img[i];
            ref_run(1000, r_ret, r_acc, r_hlt);
            wait_rand = it[0];
            w = it / 2;
            wait_fixed = w;
            do_reset();
            run_big(5000, cyc, rets, fr);
            diffs = 0;
            for (int j = 0; j < 16; j++) if (mem[100+j] !== rm[100+j]) diffs++;
            total++;
            if (diffs != 0 || !halted || !r_hlt || rets != r_ret) begin
                bad++; $display("FAIL rand_prog%0d got diffs=%0d halt=%b ret=%0d want 0/1/%0d", it, diffs, halted, rets, r_ret);
            end
            if (!wait_rand) begin
                total++;
                if (cyc != r_acc * (w + 1) + 1) begin
                    bad++; $display("FAIL rand_cycles%0d got %0d want %0d", it, cyc, r_acc * (w + 1) + 1);
                end
            end
        end
        wait_rand = 1'b0;
    endtask

    task automatic test_wrap();
        logic [4:0] exp_log [10] = '{5'd0, 5'd13, 5'd12, 5'd15, 5'd13, 5'd29, 5'd0, 5'd13, 5'd1, 5'd14};
        int cyc, diffs;
        for (int i = 0; i < 16; i++) s_img[i] = 16'd0;
        s_img[0]  = {4'hC, 4'($urandom_range(0, 15)), 4'd12, 4'd13};
        s_img[15] = {4'h1, 4'($urandom_range(0, 15)), 4'd13, 4'd1};
        s_img[1]  = {4'hD, 4'($urandom_range(0, 15)), 4'd14, 4'd1};
        s_img[12] = 16'd15;
        s_rst = 1'b1;
        repeat (2) @(negedge clk);
        s_rst = 1'b0;
        cyc = 0;
        while (!s_halted && cyc < 100) begin @(negedge clk); cyc++; end
        total++;
        if (!s_halted || s_mem[13] !== 16'd1) begin
            bad++; $display("FAIL wrap_result got halt=%b M13=%0d want 1/1", s_halted, s_mem[13]);
        end
        diffs = 0;
        for (int i = 0; i < 10; i++) if (i >= s_log.size() || s_log[i] !== exp_log[i]) diffs++;
        total++;
        if (diffs != 0 || s_log.size() != 10) begin
            bad++; $display("FAIL wrap_sequence got %0d accesses %0d wrong want 10/0", s_log.size(), diffs);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_wait_states();
        test_srl_lt();
        test_indirect();
        test_branch_halt();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
